mem_copy_initiator: RTL



---
 rtl/mem_map_pkg.sv | 14 +
 rtl/mem_copy_initiator.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_map_pkg.sv
// Memory map constants shared with the memory system, plus the copy engine state type.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h1000_0000;
  localparam int          WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } copy_state_e;

endpackage

// File: rtl/mem_copy_initiator.sv
// Bus initiator copying a block of words from ROM/RAM into RAM, one read and one write per word.
// All outputs decode registered state only; read data is captured in RD and written back in WR.
module mem_copy_initiator
  import mem_map_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = mem_map_pkg::RAM_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] src_addr_i,
  input  logic [DATA_WIDTH-1:0] dst_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_count_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output copy_state_e           dbg_state_o
);

  // Handshake: start_i is a one-cycle pulse honoured only in IDLE (ignored otherwise, no queueing);
  // every accepted request ends in exactly one done_o pulse, with err_o alongside if it was rejected.

  copy_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [DATA_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  err_q, err_d;
  logic                  reject;

  always_comb begin
    reject = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00) ||
             (dst_addr_i < RAM_BASE);
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_ptr_d   = src_addr_i;
          dst_ptr_d   = dst_addr_i;
          remaining_d = word_count_i;
          err_d       = reject;
          state_d     = (reject || (word_count_i == '0)) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        hold_d  = mem_rdata_i;
        state_d = ST_WR;
      end
      ST_WR: begin
        // Pointers wrap modulo 2^DATA_WIDTH; region bounds are the caller's concern.
        src_ptr_d   = src_ptr_q + DATA_WIDTH'(WORD_BYTES);
        dst_ptr_d   = dst_ptr_q + DATA_WIDTH'(WORD_BYTES);
        remaining_d = remaining_q - CNT_WIDTH'(1);
        state_d     = (remaining_q == CNT_WIDTH'(1)) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    mem_we_o    = (state_q == ST_WR);
    mem_addr_o  = '0;
    if (state_q == ST_RD) mem_addr_o = src_ptr_q;
    if (state_q == ST_WR) mem_addr_o = dst_ptr_q;
    // Write data is the hold register itself, so it keeps its last value outside WR.
    mem_wdata_o = hold_q;
    busy_o      = (state_q == ST_RD) || (state_q == ST_WR);
    done_o      = (state_q == ST_DONE);
    err_o       = (state_q == ST_DONE) && err_q;
    dbg_state_o = state_q;
  end

endmodule
